// File: rtl/button_event_arbiter.sv
// rtl/button_event_arbiter.sv - round-robin arbiter serializing button press pulses into one event stream
//
// Latches one-cycle press pulses per channel, grants pending channels
// round-robin, and offers one event at a time over a valid/ready handshake.
// After an event is accepted, that channel ignores new pulses for LOCKOUT
// cycles.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   btn_pulse    [N]    one-cycle press pulses, one bit per channel
//   evt_valid    event offered
//   evt_ready    consumer accepts the offered event
//   evt_id       [IDW]  channel index of the offered event
//   pending      [N]    latched presses not yet accepted
//   busy         offer in progress or any press pending
//   overrun_cnt  [CNTW] saturating count of cycles with dropped presses
//                (only when BTN_OVERRUN_CNT_EN is defined)
//
// Optional feature macro: BTN_OVERRUN_CNT_EN
module button_event_arbiter #(
  parameter int N       = 4,
  parameter int IDW     = 2,
  parameter int LOCKOUT = 16,
  parameter int CNTW    = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    btn_pulse,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [IDW-1:0]  evt_id,
  output logic [N-1:0]    pending,
  output logic            busy
`ifdef BTN_OVERRUN_CNT_EN
  ,
  output logic [CNTW-1:0] overrun_cnt
`endif
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_OFFER = 1'b1;

  // Lock counter must hold LOCKOUT itself; LOCKOUT=0 still needs one bit.
  localparam int              LW        = (LOCKOUT > 0) ? $clog2(LOCKOUT + 1) : 1;
  localparam logic [LW-1:0]   LOCK_LOAD = LW'(LOCKOUT);

  logic [0:0]     state;
  logic [IDW-1:0] last_grant;
  logic [LW-1:0]  lock [N];
  logic           accept;
  logic [N-1:0]   acc_vec;
  logic [IDW-1:0] sel_id;
  logic           sel_found;

  assign evt_valid = (state == S_OFFER);
  assign accept    = evt_valid && evt_ready;
  assign busy      = (state == S_OFFER) || (pending != '0);

  always_comb begin
    acc_vec = '0;
    for (int i = 0; i < N; i++) begin
      acc_vec[i] = accept && (evt_id == IDW'(i));
    end
  end

  // Round-robin search starting just after last_grant. Walking from the
  // farthest candidate to the nearest lets the nearest set bit win.
  always_comb begin
    int             cand;
    logic [IDW-1:0] cand_id;
    sel_id    = '0;
    sel_found = 1'b0;
    cand      = 0;
    cand_id   = '0;
    for (int k = N; k >= 1; k--) begin
      cand    = (int'(last_grant) + k) % N;
      cand_id = IDW'(cand);
      if (pending[cand_id]) begin
        sel_id    = cand_id;
        sel_found = 1'b1;
      end
    end
  end

  // Capture and lockout. A pulse on the channel being accepted sees
  // pending=1 and is dropped; the clear takes priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      for (int i = 0; i < N; i++) begin
        lock[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (acc_vec[i]) begin
          pending[i] <= 1'b0;
          lock[i]    <= LOCK_LOAD;
        end else begin
          if (btn_pulse[i] && !pending[i] && (lock[i] == '0)) begin
            pending[i] <= 1'b1;
          end
          if (lock[i] != '0) begin
            lock[i] <= lock[i] - LW'(1);
          end
        end
      end
    end
  end

  // Grant decision uses registered pending only, so same-cycle pulses
  // wait for the next arbitration.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      evt_id     <= '0;
      last_grant <= IDW'(N - 1);
    end else begin
      case (state)
        S_IDLE: begin
          if (sel_found) begin
            evt_id <= sel_id;
            state  <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (evt_ready) begin
            last_grant <= evt_id;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef BTN_OVERRUN_CNT_EN
  logic overrun_hit;
  assign overrun_hit = |(btn_pulse & pending);

  // Counts cycles with at least one dropped press, not individual drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_cnt <= '0;
    end else if (overrun_hit && (overrun_cnt != '1)) begin
      overrun_cnt <= overrun_cnt + CNTW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_button_event_arbiter.sv
// tb/tb_button_event_arbiter.sv - self-checking bench for button_event_arbiter
module tb_button_event_arbiter;
  localparam int N       = 4;
  localparam int IDW     = 2;
  localparam int LOCKOUT = 16;
  localparam int CNTW    = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   btn_pulse;
  logic           evt_ready;
  logic           evt_valid;
  logic [IDW-1:0] evt_id;
  logic [N-1:0]   pending;
  logic           busy;
`ifdef BTN_OVERRUN_CNT_EN
  logic [CNTW-1:0] overrun_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: pending set, offer flag, and per-channel absolute
  // cycle number from which new pulses are accepted again.
  bit m_pend [N];
  bit m_offer;
  int m_id;
  int m_last;
  int m_free_at [N];
  int m_ovr;
  int cyc = 0;
  int acc_ids [$];

  button_event_arbiter #(.N(N), .IDW(IDW), .LOCKOUT(LOCKOUT), .CNTW(CNTW)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_pulse (btn_pulse),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_id    (evt_id),
    .pending   (pending),
    .busy      (busy)
`ifdef BTN_OVERRUN_CNT_EN
    ,
    .overrun_cnt (overrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] pvec();
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i]    = 1'b0;
      m_free_at[i] = 0;
    end
    m_offer = 1'b0;
    m_id    = 0;
    m_last  = N - 1;
    m_ovr   = 0;
  endfunction

  function automatic void model_edge(input logic [N-1:0] p, input logic r);
    bit old_pend [N];
    bit acc;
    bit any_ovr;
    acc     = m_offer && r;
    any_ovr = 1'b0;
    for (int i = 0; i < N; i++) old_pend[i] = m_pend[i];
    for (int i = 0; i < N; i++) if (p[i] && old_pend[i]) any_ovr = 1'b1;
    if (any_ovr && m_ovr < (1 << CNTW) - 1) m_ovr++;
    for (int i = 0; i < N; i++) begin
      if (acc && i == m_id) begin
        m_pend[i]    = 1'b0;
        m_free_at[i] = cyc + LOCKOUT + 1;
      end else if (p[i] && !old_pend[i] && cyc >= m_free_at[i]) begin
        m_pend[i] = 1'b1;
      end
    end
    if (m_offer) begin
      if (r) begin
        m_offer = 1'b0;
        m_last  = m_id;
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        int ch;
        ch = (m_last + k) % N;
        if (old_pend[ch]) begin
          m_id    = ch;
          m_offer = 1'b1;
          break;
        end
      end
    end
    cyc++;
  endfunction

  // One clock: drive at negedge, compare against model, advance on posedge.
  task automatic step(input logic [N-1:0] p, input logic r);
    @(negedge clk);
    btn_pulse = p;
    evt_ready = r;
    #1;
    chk("valid", evt_valid, m_offer);
    chk("id", evt_id, m_id);
    chk("pending", pending, pvec());
    chk("busy", busy, m_offer || (pvec() != '0));
`ifdef BTN_OVERRUN_CNT_EN
    chk("overrun", overrun_cnt, m_ovr);
`endif
    if (evt_valid && r) acc_ids.push_back(int'(evt_id));
    @(posedge clk);
    model_edge(p, r);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b0;
    btn_pulse = '0;
    evt_ready = 1'b0;
    #1;
    model_reset();
    chk("rst_valid", evt_valid, 0);
    chk("rst_id", evt_id, 0);
    chk("rst_pending", pending, 0);
    chk("rst_busy", busy, 0);
`ifdef BTN_OVERRUN_CNT_EN
    chk("rst_overrun", overrun_cnt, 0);
`endif
    @(negedge clk);
    reset = 1'b1;
    acc_ids.delete();
  endtask

  initial begin
    reset     = 1'b0;
    btn_pulse = '0;
    evt_ready = 1'b0;

    // Single press on channel 2.
    do_reset();
    step(4'b0100, 1'b1);
    step(4'b0000, 1'b1);
    chk("t1_valid", evt_valid, 1);
    chk("t1_id", evt_id, 2);
    step(4'b0000, 1'b1);
    chk("t1_pending", pending, 0);
    chk("t1_busy", busy, 0);

    // Simultaneous presses 0,1,3.
    do_reset();
    step(4'b1011, 1'b1);
    for (int j = 0; j < 7; j++) step(4'b0000, 1'b1);
    chk("t2_count", acc_ids.size(), 3);
    chk("t2_first", (acc_ids.size() > 0) ? acc_ids[0] : -1, 0);
    chk("t2_second", (acc_ids.size() > 1) ? acc_ids[1] : -1, 1);
    chk("t2_third", (acc_ids.size() > 2) ? acc_ids[2] : -1, 3);
    chk("t2_busy", busy, 0);

    // Round-robin after grant of channel 1.
    do_reset();
    step(4'b0010, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    acc_ids.delete();
    step(4'b0101, 1'b1);
    for (int j = 0; j < 5; j++) step(4'b0000, 1'b1);
    chk("t3_count", acc_ids.size(), 2);
    chk("t3_first", (acc_ids.size() > 0) ? acc_ids[0] : -1, 2);
    chk("t3_second", (acc_ids.size() > 1) ? acc_ids[1] : -1, 0);

    // Lockout window on channel 0; acceptance at the third edge.
    do_reset();
    step(4'b0001, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    for (int j = 0; j < 4; j++) step(4'b0000, 1'b1);
    step(4'b0001, 1'b1);
    chk("t4_ignored5", pending[0], 0);
`ifdef BTN_OVERRUN_CNT_EN
    chk("t4_no_overrun", overrun_cnt, 0);
`endif
    for (int j = 0; j < 10; j++) step(4'b0000, 1'b1);
    step(4'b0001, 1'b1);
    chk("t4_ignored16", pending[0], 0);
    step(4'b0001, 1'b1);
    chk("t4_captured17", pending[0], 1);

    // Backpressure and overrun on channel 1.
    do_reset();
    step(4'b0010, 1'b0);
    step(4'b0000, 1'b0);
    for (int j = 0; j < 10; j++) begin
      step((j == 2) ? 4'b0010 : 4'b0000, 1'b0);
      chk("t5_hold_valid", evt_valid, 1);
      chk("t5_hold_id", evt_id, 1);
    end
`ifdef BTN_OVERRUN_CNT_EN
    chk("t5_overrun", overrun_cnt, 1);
`endif
    acc_ids.delete();
    for (int j = 0; j < 7; j++) step(4'b0000, 1'b1);
    chk("t5_count", acc_ids.size(), 1);
    chk("t5_id", (acc_ids.size() > 0) ? acc_ids[0] : -1, 1);

    // Asynchronous reset while offering.
    do_reset();
    step(4'b1000, 1'b0);
    step(4'b0000, 1'b0);
    chk("t6_pre_valid", evt_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_valid", evt_valid, 0);
    chk("t6_async_pending", pending, 0);
    chk("t6_async_busy", busy, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    acc_ids.delete();
    for (int j = 0; j < 5; j++) step(4'b0000, 1'b1);
    chk("t6_no_event", acc_ids.size(), 0);

    // Randomized traffic against the model.
    do_reset();
    for (int j = 0; j < 400; j++) begin
      logic [N-1:0] p;
      logic         r;
      p = N'($urandom & $urandom);
      r = ($urandom_range(0, 9) < 7);
      step(p, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_event_arbiter.md
# button_event_arbiter

Collects single-cycle press pulses from several push-button detector instances and turns them into one serialized event stream. Pending presses are latched per button and granted round-robin. Events are offered to the consuming control logic over a valid/ready handshake. A per-button lockout window suppresses re-triggers after each accepted event.

## Interface

Parameters:
- `N`, default 4: number of button channels.
- `IDW`, default 2: width of the event id; must satisfy 2^IDW ≥ N.
- `LOCKOUT`, default 16: cycles a channel ignores new pulses after its event is accepted; 0 disables lockout.
- `CNTW`, default 8: overrun counter width.

Ports:
- `clk` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `btn_pulse` in N: one-cycle press pulses, one bit per detector output.
- `evt_valid` out 1: an event is offered.
- `evt_ready` in 1: consumer accepts the event when high with `evt_valid`.
- `evt_id` out IDW: channel index of the offered event.
- `pending` out N: latched, not-yet-accepted presses.
- `busy` out 1: high when state is OFFER or `pending` is non-zero.
- `overrun_cnt` out CNTW: dropped-press count; present only with `BTN_OVERRUN_CNT_EN`.

## Operation

Channel capture, per channel i, on each edge:
- If `btn_pulse[i]`=1, `pending[i]`=0 and `lock[i]`=0: set `pending[i]`.
- If `btn_pulse[i]`=1 and `pending[i]`=1: the press is dropped and counts as an overrun.
- If `btn_pulse[i]`=1, `pending[i]`=0 and `lock[i]`≠0: the press is ignored. It is not an overrun.
- `lock[i]` is a down-counter that saturates at 0.
  - It loads `LOCKOUT` on the edge where channel i's event is accepted.
  - It otherwise decrements while non-zero.

FSM, with states IDLE and OFFER:
- **IDLE:** `evt_valid`=0.
  - If `pending`≠0, select the first set bit searching from `last_grant+1` upward, wrapping modulo N.
  - Register that bit's index into `evt_id` and go to OFFER.
- **OFFER:** `evt_valid`=1.
  - `evt_id` is held stable until acceptance.
  - On `evt_valid && evt_ready`: clear `pending[evt_id]`, load `lock[evt_id]`, set `last_grant` to `evt_id`, and return to IDLE.
- Grant is round-robin. A channel that was just granted has lowest priority at the next arbitration.

Boundary rules:
- A pulse on the channel being accepted, in the acceptance cycle itself, sees `pending`=1. It is dropped and counted as an overrun.
- Pulses on other channels are captured normally in any state, including during a stall with `evt_ready` low.
- The grant decision uses the registered `pending` value. A pulse arriving in the same cycle as the IDLE decision is considered at the next arbitration.
- Reset asserted mid-offer immediately clears all outputs. The event is lost.

## Timing

Reset values:
- `evt_valid`=0, `evt_id`=0, `pending`=0, `busy`=0, `overrun_cnt`=0.
- All `lock` counters = 0, `last_grant`=N-1, so channel 0 has first priority.
- State = IDLE.

Latency:
- A pulse at edge t sets `pending` at t+1.
- `evt_valid` rises at t+2 if the FSM is in IDLE at t+1.

Throughput:
- Peak is one event per 2 cycles (OFFER → IDLE → OFFER), with `evt_ready` held high.

## Configuration

`BTN_OVERRUN_CNT_EN`:
- **Defined:** `overrun_cnt` port and counter exist. The counter increments by 1 per cycle in which one or more overruns occur, and saturates at 2^CNTW−1.
- **Undefined:** the port and counter are absent. Dropped presses are discarded silently; all other behaviour is identical.

## Test plan

All scenarios use N=4, LOCKOUT=16.

1. **Single press:** release reset, then pulse `btn_pulse[2]` at edge t with `evt_ready`=1.
   - `evt_valid`=1 and `evt_id`=2 at t+2.
   - `pending`=0 and `busy`=0 at t+3.
2. **Simultaneous presses:** pulse channels 0, 1 and 3 together with `evt_ready` held high.
   - Events 0, 1, 3 are offered in that order, 2 cycles apart.
   - `busy` drops after the last acceptance.
3. **Round-robin order:** after an accepted grant of 1, pulse channels 0 and 2 together.
   - Event 2 is offered before event 0.
4. **Lockout window:** accept an event on channel 0.
   - A re-pulse 5 cycles later is ignored: `pending[0]` stays 0 and `overrun_cnt` is unchanged.
   - A pulse 17 cycles after acceptance is captured.
5. **Backpressure and overrun:** hold `evt_ready`=0 for 10 cycles during an offer of channel 1 and pulse channel 1 again.
   - `evt_valid`/`evt_id` stay at 1/1 throughout.
   - `overrun_cnt`=1.
   - After `evt_ready` rises, exactly one event on channel 1 is delivered.
6. **Reset in OFFER:** drive `reset` low asynchronously mid-cycle while in OFFER.
   - `evt_valid`, `pending` and `busy` go to 0 without waiting for a clock edge.
   - After reset release, no event is offered until a new pulse arrives.
